// File: rtl/branch_resolve_queue_if.sv
// Bundle of fetch, predictor and execute signals around the branch resolve queue.
// The block owns the slave view; fetch/execute/predictor logic owns the master view.
interface branch_resolve_queue_if #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 16
);
  // Handshake: a fetch is accepted on a rising edge where fetch_valid & fetch_ready;
  // fetch_ready never depends on fetch_valid. All strobes are one-cycle registered pulses.
  logic             fetch_valid;
  logic             fetch_ready;
  logic             request;
  logic             prediction;
  logic             pred_valid;
  logic             pred_taken;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             result;
  logic             taken;
  logic             mispredict;
  logic [PTR_W:0]   occupancy;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic             underflow_err;

  modport master (
    output fetch_valid, prediction, resolve_valid, resolve_taken,
    input  fetch_ready, request, pred_valid, pred_taken, result, taken,
           mispredict, occupancy, branch_cnt, mispred_cnt, underflow_err
  );

  modport slave (
    input  fetch_valid, prediction, resolve_valid, resolve_taken,
    output fetch_ready, request, pred_valid, pred_taken, result, taken,
           mispredict, occupancy, branch_cnt, mispred_cnt, underflow_err
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of branch predictions between fetch/execute and a 2-bit predictor,
// with mispredict flush and saturating branch/mispredict statistics.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_queue_if.slave bus
);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] q;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             inflight;
  logic             accept;
  logic             pop;
  logic             mis;
  logic             push;
  logic             under;

  // The in-flight lookup reserves a slot so its capture can never overflow the queue.
  assign bus.occupancy   = count + {{PTR_W{1'b0}}, inflight};
  assign bus.fetch_ready = (bus.occupancy < DEPTH_C) & ~bus.mispredict;
  assign bus.request     = inflight;

  assign accept = bus.fetch_valid & bus.fetch_ready;
  assign pop    = bus.resolve_valid & (count != '0);
  assign under  = bus.resolve_valid & (count == '0);
  assign mis    = pop & (q[head] != bus.resolve_taken);
  // A mispredict squashes the in-flight capture and any fetch accepted on the same edge.
  assign push   = inflight & ~mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q               <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      inflight        <= 1'b0;
      bus.pred_valid  <= 1'b0;
      bus.pred_taken  <= 1'b0;
      bus.result      <= 1'b0;
      bus.taken       <= 1'b0;
      bus.mispredict  <= 1'b0;
      bus.branch_cnt  <= '0;
      bus.mispred_cnt <= '0;
      bus.underflow_err <= 1'b0;
    end else begin
      inflight       <= accept & ~mis;
      bus.pred_valid <= push;
      bus.pred_taken <= push & bus.prediction;
      bus.result     <= pop;
      bus.taken      <= pop & bus.resolve_taken;
      bus.mispredict <= mis;

      if (push) q[tail] <= bus.prediction;

      if (mis) begin
        head  <= head + 1'b1;
        tail  <= head + 1'b1;
        count <= '0;
      end else begin
        if (pop)  head <= head + 1'b1;
        if (push) tail <= tail + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end

      if (pop && bus.branch_cnt != CNT_MAX)  bus.branch_cnt  <= bus.branch_cnt + 1'b1;
      if (mis && bus.mispred_cnt != CNT_MAX) bus.mispred_cnt <= bus.mispred_cnt + 1'b1;
      if (under) bus.underflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue with a queue-based reference
// model, an emulated 2-bit predictor and a scoreboard monitor.
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  branch_resolve_queue_if #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) bif ();

  branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  bit       mq[$];
  bit       m_inflight;
  bit       m_mis;
  bit       m_res;
  bit       m_taken;
  bit       m_pv;
  bit       m_pt;
  int       m_bc;
  int       m_mc;
  bit       m_uf;
  logic [0:0] exp_pred_q[$];
  logic [1:0] exp_res_q[$];
  logic [1:0] ctr = 2'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      exp_pred_q.delete();
      exp_res_q.delete();
      m_inflight = 0; m_mis = 0; m_res = 0; m_taken = 0;
      m_pv = 0; m_pt = 0; m_bc = 0; m_mc = 0; m_uf = 0;
    end else begin
      int occ;
      bit acc, popping, mis, h;
      occ     = mq.size() + int'(m_inflight);
      acc     = bif.fetch_valid && (occ < DEPTH) && !m_mis;
      popping = bif.resolve_valid && (mq.size() != 0);
      if (bif.resolve_valid && mq.size() == 0) m_uf = 1;
      mis = 0;
      if (popping) begin
        h   = mq.pop_front();
        mis = (h != bif.resolve_taken);
        exp_res_q.push_back({bif.resolve_taken, mis});
        if (m_bc < CMAX) m_bc++;
        if (mis && m_mc < CMAX) m_mc++;
      end
      m_pv = 0;
      m_pt = 0;
      if (mis) mq.delete();
      else if (m_inflight) begin
        mq.push_back(bif.prediction);
        exp_pred_q.push_back(bif.prediction);
        m_pv = 1;
        m_pt = bif.prediction;
      end
      m_inflight = acc && !mis;
      m_mis      = mis;
      m_res      = popping;
      m_taken    = popping && bif.resolve_taken;
    end
  end

  // 2-bit saturating predictor: trains on the result strobe before the next sample
  always @(negedge clk) begin
    if (m_res) begin
      if (m_taken && ctr != 2'd3) ctr = ctr + 2'd1;
      else if (!m_taken && ctr != 2'd0) ctr = ctr - 2'd1;
    end
    bif.prediction = ctr[1];
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [0:0] ep;
    logic [1:0] er;
    if (bif.pred_valid) begin
      if (exp_pred_q.size() == 0) chk("pred_unexpected", 1, 0);
      else begin
        ep = exp_pred_q.pop_front();
        chk("pred_taken", bif.pred_taken, ep);
      end
    end
    if (bif.result) begin
      if (exp_res_q.size() == 0) chk("result_unexpected", 1, 0);
      else begin
        er = exp_res_q.pop_front();
        chk("taken", bif.taken, er[1]);
        chk("mispredict_val", bif.mispredict, er[0]);
      end
    end
    chk("pred_valid", bif.pred_valid, m_pv);
    chk("result", bif.result, m_res);
    chk("mispredict", bif.mispredict, m_mis);
    chk("request", bif.request, m_inflight);
    chk("occupancy", bif.occupancy, mq.size() + int'(m_inflight));
    chk("fetch_ready", bif.fetch_ready, ((mq.size() + int'(m_inflight)) < DEPTH) && !m_mis);
    chk("branch_cnt", bif.branch_cnt, m_bc);
    chk("mispred_cnt", bif.mispred_cnt, m_mc);
    chk("underflow_err", bif.underflow_err, m_uf);
  end

  // driver
  task automatic drive(input bit fv, input bit rv, input bit rt);
    bif.fetch_valid   = fv;
    bif.resolve_valid = rv;
    bif.resolve_taken = rt;
    @(negedge clk);
  endtask

  initial begin
    bit f;
    rst = 1'b1;
    bif.fetch_valid = 1'b0;
    bif.resolve_valid = 1'b0;
    bif.resolve_taken = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_occupancy", bif.occupancy, 0);
    chk("rst_request", bif.request, 0);
    chk("rst_pred_valid", bif.pred_valid, 0);

    // single lookup: request then prediction two edges after accept
    drive(1, 0, 0);
    chk("t1_request", bif.request, 1);
    drive(0, 0, 0);
    chk("t1_pred_valid", bif.pred_valid, 1);
    chk("t1_pred_taken", bif.pred_taken, 0);
    chk("t1_occupancy", bif.occupancy, 1);

    // three taken resolves, each followed by a new lookup
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1);
      chk("t2_taken", bif.taken, 1);
      drive(0, 0, 0);
      drive(1, 0, 0);
      drive(0, 0, 0);
      drive(0, 0, 0);
    end
    chk("t2_branch_cnt", bif.branch_cnt, 3);
    chk("t2_mispred_cnt", bif.mispred_cnt, 2);
    drive(0, 1, 1);
    drive(0, 0, 0);
    drive(0, 0, 0);

    // fill to capacity
    repeat (10) drive(1, 0, 0);
    chk("t3_occupancy", bif.occupancy, 8);
    chk("t3_fetch_ready", bif.fetch_ready, 0);
    drive(0, 0, 0);
    repeat (4) drive(0, 1, mq[0]);
    drive(0, 0, 0);
    chk("t4_occupancy_pre", bif.occupancy, 4);

    // oldest mispredicts while a lookup is in flight
    drive(1, 0, 0);
    drive(0, 1, !mq[0]);
    chk("t4_mispredict", bif.mispredict, 1);
    chk("t4_occupancy", bif.occupancy, 0);
    chk("t4_result", bif.result, 1);
    chk("t4_fetch_ready", bif.fetch_ready, 0);
    drive(0, 0, 0);
    chk("t4_no_pred_valid", bif.pred_valid, 0);

    // resolve on empty queue
    drive(0, 1, 1);
    chk("t5_result", bif.result, 0);
    chk("t5_underflow", bif.underflow_err, 1);
    repeat (3) drive(0, 0, 0);
    chk("t5_underflow_sticky", bif.underflow_err, 1);

    // asynchronous reset mid-lookup
    repeat (5) drive(1, 0, 0);
    chk("t6_occupancy", bif.occupancy, 5);
    bif.fetch_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_request", bif.request, 0);
    chk("t6_occupancy_rst", bif.occupancy, 0);
    chk("t6_pred_valid_rst", bif.pred_valid, 0);
    chk("t6_underflow_rst", bif.underflow_err, 0);
    chk("t6_branch_cnt_rst", bif.branch_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0);
    chk("t6_no_pred_valid", bif.pred_valid, 0);
    drive(0, 0, 0);

    // randomized traffic; counters are narrow so saturation is reached
    for (int i = 0; i < 800; i++) begin
      if (mq.size() != 0) f = ($urandom_range(0, 3) == 0) ? !mq[0] : mq[0];
      else f = bit'($urandom_range(0, 1));
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, f);
    end
    chk("rand_branch_sat", bif.branch_cnt, CMAX);
    repeat (4) drive(0, 0, 0);
    chk("pred_q_drained", exp_pred_q.size(), 0);
    chk("res_q_drained", exp_res_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
